// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Purpose:
//   A single-clock byte FIFO that feeds the UART transmit path. The output is
//   first-word-fall-through (FWFT): the head byte is always visible on
//   tx_dfifo while the FIFO holds data, and the FIFO drives 0 when it is empty.
//   The host pushes bytes at burst rate and uses afull for flow control. The
//   transmitter pops one byte per frame with rd_en.
//
// Configuration:
//   UART_FIFO_ERR_EN  When this macro is defined, the module adds the sticky
//                     error flags ovf and udf and their clear input err_clr.
//                     When it is undefined, rejected operations are dropped
//                     silently.
//
// Parameters:
//   DW          data width in bits (default 8)
//   DEPTH_LOG2  log2 of the storage depth (default 4, which gives 16 entries)
//   AF_LEVEL    afull asserts when count >= AF_LEVEL; legal range is
//               1..2**DEPTH_LOG2
//
// Ports:
//   clk       in   1             system clock, rising edge
//   rstn      in   1             asynchronous active-low reset
//   wr_en     in   1             host push request
//   wr_data   in   DW            byte to push
//   full      out  1             no free entry; pushes are rejected
//   afull     out  1             count >= AF_LEVEL
//   rd_en     in   1             transmitter pop request
//   tx_dfifo  out  DW            head byte (FWFT), or 0 when empty
//   empty     out  1             no stored byte
//   ovf       out  1             sticky rejected-push flag   (ERR_EN only)
//   udf       out  1             sticky rejected-pop flag    (ERR_EN only)
//   err_clr   in   1             clears ovf/udf next edge    (ERR_EN only)
//   count     out  DEPTH_LOG2+1  stored entries, 0..2**DEPTH_LOG2
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int unsigned DW         = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned AF_LEVEL   = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [DW-1:0]         wr_data,
    output logic                  full,
    output logic                  afull,
    input  logic                  rd_en,
    output logic [DW-1:0]         tx_dfifo,
    output logic                  empty,
`ifdef UART_FIFO_ERR_EN
    output logic                  ovf,
    output logic                  udf,
    input  logic                  err_clr,
`endif
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned AW    = DEPTH_LOG2;      // storage address width
    localparam int unsigned PW    = DEPTH_LOG2 + 1;  // pointer width (extra wrap bit)
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    // The threshold is held at pointer width so that the compare has matching
    // widths. AF_LEVEL = DEPTH still fits because count reaches DEPTH.
    localparam logic [PW-1:0] AF_THR = AF_LEVEL[PW-1:0];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [PW-1:0] w_count;

    // -------------------------------------------------------------------------
    // Flags, derived combinationally from the registered pointers.
    // The pointers are equal when the FIFO is empty. When the FIFO is full,
    // the addresses are equal but the wrap bits differ, because the write
    // pointer is exactly one lap ahead of the read pointer.
    // -------------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW]     != r_rd_ptr[AW]);
    assign w_count = r_wr_ptr - r_rd_ptr;   // modulo 2**PW gives 0..DEPTH

    // A push on a full FIFO is rejected even when a pop happens in the same
    // cycle. There is no pass-through path, so the host must retry the push.
    assign w_push  = wr_en && !w_full;
    assign w_pop   = rd_en && !w_empty;

    assign full    = w_full;
    assign empty   = w_empty;
    assign count   = w_count;
    assign afull   = (w_count >= AF_THR);

    // FWFT head. The storage is not reset, so the output is forced to 0 while
    // the FIFO is empty. This also makes tx_dfifo read 0 as soon as rstn
    // asserts.
    assign tx_dfifo = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // -------------------------------------------------------------------------
    // Pointers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so that every register
    // samples the pre-edge values, no matter how the processes are ordered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset. Its contents are only observable
    // through tx_dfifo, and tx_dfifo is gated by empty. Leaving the reset off
    // lets the array map onto plain RAM or flops without a reset net.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    // -------------------------------------------------------------------------
    // Optional sticky error flags
    // -------------------------------------------------------------------------
`ifdef UART_FIFO_ERR_EN
    logic r_ovf;
    logic r_udf;

    // When a set event and err_clr occur in the same cycle, the set event
    // wins. This ensures that a clear racing a fresh error never hides it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr_en && w_full)       r_ovf <= 1'b1;
            else if (err_clr)          r_ovf <= 1'b0;

            if (rd_en && w_empty)      r_udf <= 1'b1;
            else if (err_clr)          r_udf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`else
    // Without error reporting, a rejected push or pop leaves no trace.
    // The guards on w_push and w_pop above already drop it.
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo.
//
// Inputs are driven on the falling edge, and outputs are checked 1 time unit
// after the rising edge. A byte queue acts as both the reference model and the
// scoreboard. An accepted push appends the byte to the queue. An accepted pop
// first compares the head byte on the DUT with the front of the queue, then
// removes that entry from the queue. After every cycle, the occupancy flags
// are compared against the queue size.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic             clk;
    logic             rstn;
    logic             wr_en;
    logic [DW-1:0]    wr_data;
    logic             full;
    logic             afull;
    logic             rd_en;
    logic [DW-1:0]    tx_dfifo;
    logic             empty;
    logic [DL2:0]     count;
`ifdef UART_FIFO_ERR_EN
    logic             ovf;
    logic             udf;
    logic             err_clr;
`endif

    uart_tx_fifo #(
        .DW         (DW),
        .DEPTH_LOG2 (DL2),
        .AF_LEVEL   (AFL)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .afull    (afull),
        .rd_en    (rd_en),
        .tx_dfifo (tx_dfifo),
        .empty    (empty),
`ifdef UART_FIFO_ERR_EN
        .ovf      (ovf),
        .udf      (udf),
        .err_clr  (err_clr),
`endif
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: stored bytes in arrival order, plus the sticky error
    // flags.
    logic [DW-1:0] sb[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic check_state(input string tag);
        int n;
        n = sb.size();
        check({tag, ".count"}, 32'(count), 32'(n));
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".full"},  32'(full),  32'(n == DEPTH));
        check({tag, ".afull"}, 32'(afull), 32'(n >= AFL));
        check({tag, ".head"},  32'(tx_dfifo), (n == 0) ? 32'd0 : 32'(sb[0]));
`ifdef UART_FIFO_ERR_EN
        check({tag, ".ovf"},   32'(ovf), 32'(m_ovf));
        check({tag, ".udf"},   32'(udf), 32'(m_udf));
`endif
    endtask

    // Drive one clock cycle of stimulus and update the model.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd,
                        input logic clr, input string tag);
        int  pre;
        bit  push_ok;
        bit  pop_ok;
        @(negedge clk);
        pre     = sb.size();
        push_ok = wr && (pre < DEPTH);
        pop_ok  = rd && (pre > 0);
        // The FWFT head must be the oldest byte before the pop consumes it.
        if (pop_ok) check({tag, ".pop"}, 32'(tx_dfifo), 32'(sb[0]));
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
`ifdef UART_FIFO_ERR_EN
        err_clr = clr;
        if (wr && pre == DEPTH) m_ovf = 1'b1;
        else if (clr)           m_ovf = 1'b0;
        if (rd && pre == 0)     m_udf = 1'b1;
        else if (clr)           m_udf = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (pop_ok)  void'(sb.pop_front());
        if (push_ok) sb.push_back(d);
        wr_en = 1'b0;
        rd_en = 1'b0;
`ifdef UART_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
        check_state(tag);
    endtask

    // Vector table for the short single-step sequence.
    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
        logic          rd;
        logic          clr;
        logic [DL2:0]  exp_count;
        logic          exp_empty;
        logic [DW-1:0] exp_dout;
        logic          exp_udf;
    } vec_t;

    vec_t vecs[11];
    logic [DW-1:0] lb_bytes[3];
    logic [DW-1:0] rx[$];

    initial begin
        // Columns:     wr    data   rd    clr   count empty dout   udf
        vecs[0]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 5'd1, 1'b0, 8'h5A, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 5'd1, 1'b0, 8'h3C, 1'b0};
        vecs[3]  = '{1'b1, 8'h77, 1'b0, 1'b0, 5'd2, 1'b0, 8'h3C, 1'b0};
        vecs[4]  = '{1'b1, 8'h99, 1'b1, 1'b0, 5'd2, 1'b0, 8'h77, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 8'h99, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 1'b1, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 8'h00, 1'b0};
        lb_bytes[0] = 8'h5A;
        lb_bytes[1] = 8'h3C;
        lb_bytes[2] = 8'hC3;

        rstn    = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
`ifdef UART_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Table: single push and pop, simultaneous operations, and underflow
        // with err_clr.
        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].data, vecs[i].rd, vecs[i].clr, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_count", i), 32'(count),    32'(vecs[i].exp_count));
            check($sformatf("vec%0d.tbl_empty", i), 32'(empty),    32'(vecs[i].exp_empty));
            check($sformatf("vec%0d.tbl_dout", i),  32'(tx_dfifo), 32'(vecs[i].exp_dout));
`ifdef UART_FIFO_ERR_EN
            check($sformatf("vec%0d.tbl_udf", i),   32'(udf),      32'(vecs[i].exp_udf));
`endif
        end

        // Fill to full. afull rises with the 12th byte and full rises with
        // the 16th byte.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, $sformatf("fill%0d", i));
            check($sformatf("fill%0d.afull_bnd", i), 32'(afull), 32'(i + 1 >= AFL));
            check($sformatf("fill%0d.full_bnd", i),  32'(full),  32'(i + 1 == DEPTH));
        end
        step(1'b1, 8'hFF, 1'b0, 1'b0, "ovf_push");
`ifdef UART_FIFO_ERR_EN
        check("ovf_set", 32'(ovf), 32'd1);
`endif
        // A push and a pop in the same cycle while full: only the pop is
        // accepted.
        step(1'b1, 8'hEE, 1'b1, 1'b0, "full_wr_rd");
        check("full_wr_rd.count", 32'(count), 32'd15);
        step(1'b0, 8'h00, 1'b0, 1'b1, "ovf_clr");
        while (sb.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");

        // Steady push and pop at count = 3. The pointers wrap several times.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "pre3");
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, $sformatf("steady%0d", i));
            check($sformatf("steady%0d.cnt3", i), 32'(count), 32'd3);
        end
        while (sb.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, "drain2");

        // Assert reset asynchronously in the middle of a burst.
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "burst");
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        sb.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check("arst.empty", 32'(empty), 32'd1);
        check("arst.count", 32'(count), 32'd0);
        check("arst.full",  32'(full),  32'd0);
        check("arst.dout",  32'(tx_dfifo), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step(1'b1, 8'hA5, 1'b0, 1'b0, "post_rst");
        check("post_rst.dout", 32'(tx_dfifo), 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_pop");

        // Transmitter-style consumer. The host pushes three bytes, and one
        // byte is popped every 8 cycles, once per frame. The loop has a fixed
        // cycle budget.
        begin
            int pushed;
            pushed = 0;
            rx.delete();
            for (int cyc = 0; cyc < 100 && rx.size() < 3; cyc++) begin
                logic do_wr;
                logic do_rd;
                do_wr = (pushed < 3);
                do_rd = (cyc % 8 == 7) && (sb.size() > 0);
                if (do_rd) rx.push_back(tx_dfifo);
                step(do_wr, do_wr ? lb_bytes[pushed] : 8'h00, do_rd, 1'b0, "loop");
                if (do_wr) pushed++;
                check("loop.no_afull", 32'(afull), 32'd0);
            end
            check("loop.rx_count", 32'(rx.size()), 32'd3);
            for (int i = 0; i < 3; i++)
                check($sformatf("loop.rx%0d", i), (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD,
                      32'(lb_bytes[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
